arbitrated_multiplexer: RTL and testbench
=========================================

ARBITRATED_MULTIPLEXER -- requirements
Module: arbitrated_multiplexer

Interface
REQ-001 SHALL have parameter width, default 1, data bits per channel.
REQ-002 SHALL have parameter channels, default 4, number of input channels, legal range 2..16.
REQ-003 SHALL have parameter channel_width, default 2, index bits; 2**channel_width >= channels required.
REQ-004 SHALL have parameter round_robin, default 1; 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-005 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have: i_data  input  channels*width  channel k data at bits [k*width +: width].
REQ-008 SHALL have: i_valid  input  channels  per-channel request, bit k = channel k.
REQ-009 SHALL have: o_ready  output  channels  per-channel accept, combinational.
REQ-010 SHALL have: o_data  output  width  registered selected data.
REQ-011 SHALL have: o_valid  output  1  o_data/o_channel hold a word.
REQ-012 SHALL have: o_channel  output  channel_width  source index of current word.
REQ-013 SHALL have: i_ready  input  1  downstream accept.
REQ-014 SHALL have: o_contention  output  1  one-cycle flag, registered.

Function
REQ-015 SHALL define load = !o_valid | i_ready; transfer on channel k = i_valid[k] & o_ready[k].
REQ-016 SHALL assert o_ready only when load=1, for exactly one channel (the winner), and only if that channel's i_valid=1; all other bits 0.
REQ-017 SHALL, in fixed-priority mode, choose the lowest k with i_valid[k]=1.
REQ-018 SHALL, in round-robin mode, search from index last+1 upward, wrapping at channels-1 to 0, choosing the first k with i_valid[k]=1; last itself is searched last.
REQ-019 SHALL update last <= winner only on a transfer; last unchanged otherwise.
REQ-020 SHALL, on a transfer, register o_data <= channel winner data, o_channel <= winner, o_valid <= 1 (latency 1 cycle).
REQ-021 SHALL, when load=1 and no i_valid bit set, register o_valid <= 0; o_data and o_channel hold.
REQ-022 SHALL, when o_valid=1 and i_ready=0, hold o_data, o_channel, o_valid and last unchanged; o_ready=0.
REQ-023 SHALL sustain one transfer per cycle while i_ready=1 (simultaneous drain and refill).
REQ-024 SHALL set o_contention <= 1 for the cycle after a transfer when two or more i_valid bits were set in the transfer cycle; otherwise o_contention <= 0.
REQ-025 SHALL ignore i_valid bits at indices >= channels (none exist); o_channel never exceeds channels-1.
REQ-026 SHALL treat i_ready while o_valid=0 as don't-care (load=1 regardless).

Reset
REQ-027 SHALL, while rst=1, force o_valid=0, o_data=0, o_channel=0, o_contention=0, last=channels-1 (so channel 0 is first searched), independent of clk.
REQ-028 SHALL hold o_ready=0 while rst=1.
REQ-029 SHALL discard any word held at reset assertion mid-operation; no transfer counted.
REQ-030 SHALL resume arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-031 SHALL cover: width=8, rr=1, i_valid=4'b1111, data k = 8'hA0+k, i_ready=1 -> o_channel 0,1,2,3,0 on consecutive cycles, o_contention=1 each cycle after first transfer.
REQ-032 SHALL cover: rr=0, i_valid=4'b1010, i_ready=1 for 3 cycles -> o_channel=1 every cycle, o_ready=4'b0010, channel 3 starved.
REQ-033 SHALL cover: o_valid=1, o_channel=2, i_ready=0 for 5 cycles with i_valid changing -> o_data/o_channel stable, o_ready=0; i_ready=1 then reloads next winner after 2 in round-robin order.
REQ-034 SHALL cover: single i_valid=4'b0100 one cycle -> o_valid=1, o_channel=2, o_contention=0; next cycle i_valid=0, i_ready=1 -> o_valid=0, o_data holds.
REQ-035 SHALL cover: rst pulsed asynchronously between edges while o_valid=1 -> immediately o_valid=0, o_data=0, o_channel=0; next grant with i_valid=4'b1001 is channel 0.
REQ-036 SHALL cover: channels=5, channel_width=3, last=4, i_valid=5'b10001 -> winner 0 (wrap), then 4.

Source files
------------

// File: rtl/arbitrated_multiplexer.sv
// N-to-1 arbitrated multiplexer with registered output stage.
// Round-robin or fixed-priority grant, one word per cycle.
module arbitrated_multiplexer #(
  parameter int width         = 1,
  parameter int channels      = 4,
  parameter int channel_width = 2,
  parameter int round_robin   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [channels*width-1:0]   i_data,
  input  logic [channels-1:0]         i_valid,
  output logic [channels-1:0]         o_ready,
  output logic [width-1:0]            o_data,
  output logic                        o_valid,
  output logic [channel_width-1:0]    o_channel,
  input  logic                        i_ready,
  output logic                        o_contention
);

  localparam logic [channel_width-1:0] LastInit =
    channel_width'(channels - 1);

  logic [width-1:0]         data_q, data_d;
  logic                     valid_q, valid_d;
  logic [channel_width-1:0] chan_q, chan_d;
  logic [channel_width-1:0] last_q, last_d;
  logic                     cont_q, cont_d;

  logic                     load;
  logic                     found;
  logic                     multi;
  logic                     xfer;
  logic [channel_width-1:0] win;
  logic [width-1:0]         sel;

  assign load = !valid_q || i_ready;

  // Winner search: rotate from last+1 in round-robin, else from 0.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    if (round_robin != 0) begin
      for (int off = 1; off <= channels; off++) begin
        idx = (int'(last_q) + off) % channels;
        if (!found && i_valid[idx]) begin
          found = 1'b1;
          win   = channel_width'(idx);
        end
      end
    end else begin
      for (int k = 0; k < channels; k++) begin
        if (!found && i_valid[k]) begin
          found = 1'b1;
          win   = channel_width'(k);
        end
      end
    end
  end

  always_comb begin
    int cnt;
    cnt = 0;
    for (int k = 0; k < channels; k++) begin
      if (i_valid[k]) cnt++;
    end
    multi = (cnt >= 2);
  end

  always_comb begin
    sel = '0;
    for (int k = 0; k < channels; k++) begin
      if (channel_width'(k) == win) sel = i_data[k*width +: width];
    end
  end

  assign xfer = found && load && !rst;

  always_comb begin
    o_ready = '0;
    if (xfer) o_ready[win] = 1'b1;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    last_d  = last_q;
    cont_d  = 1'b0;
    if (xfer) begin
      data_d  = sel;
      valid_d = 1'b1;
      chan_d  = win;
      last_d  = win;
      cont_d  = multi;
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      last_q  <= LastInit;
      cont_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
      cont_q  <= cont_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_channel    = chan_q;
  assign o_contention = cont_q;

endmodule

// File: tb/tb_arbitrated_multiplexer.sv
// Bench for arbitrated_multiplexer: round-robin, fixed-priority
// and five-channel instances driven from vectors and a scoreboard.
module tb_arbitrated_multiplexer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Round-robin, 4 channels
  logic [31:0] rr_d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [3:0]  rr_v = '0;
  logic        rr_ir = 1'b1;
  logic [3:0]  rr_or;
  logic [7:0]  rr_od;
  logic        rr_ov;
  logic [1:0]  rr_oc;
  logic        rr_ct;

  // Fixed priority, 4 channels
  logic [31:0] fp_d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [3:0]  fp_v = '0;
  logic        fp_ir = 1'b1;
  logic [3:0]  fp_or;
  logic [7:0]  fp_od;
  logic        fp_ov;
  logic [1:0]  fp_oc;
  logic        fp_ct;

  // Round-robin, 5 channels
  logic [39:0] c5_d = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [4:0]  c5_v = '0;
  logic        c5_ir = 1'b1;
  logic [4:0]  c5_or;
  logic [7:0]  c5_od;
  logic        c5_ov;
  logic [2:0]  c5_oc;
  logic        c5_ct;

  arbitrated_multiplexer #(
    .width(8), .channels(4), .channel_width(2), .round_robin(1)
  ) u_rr (
    .clk(clk), .rst(rst), .i_data(rr_d), .i_valid(rr_v),
    .o_ready(rr_or), .o_data(rr_od), .o_valid(rr_ov),
    .o_channel(rr_oc), .i_ready(rr_ir), .o_contention(rr_ct)
  );

  arbitrated_multiplexer #(
    .width(8), .channels(4), .channel_width(2), .round_robin(0)
  ) u_fp (
    .clk(clk), .rst(rst), .i_data(fp_d), .i_valid(fp_v),
    .o_ready(fp_or), .o_data(fp_od), .o_valid(fp_ov),
    .o_channel(fp_oc), .i_ready(fp_ir), .o_contention(fp_ct)
  );

  arbitrated_multiplexer #(
    .width(8), .channels(5), .channel_width(3), .round_robin(1)
  ) u_c5 (
    .clk(clk), .rst(rst), .i_data(c5_d), .i_valid(c5_v),
    .o_ready(c5_or), .o_data(c5_od), .o_valid(c5_ov),
    .o_channel(c5_oc), .i_ready(c5_ir), .o_contention(c5_ct)
  );

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] e_rdy;
    logic       e_vld;
    int         e_ch;
    logic       e_cont;
  } vec_t;

  typedef struct {
    int         inst;
    logic       vld;
    int         ch;
    logic [7:0] data;
    logic       cont;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[18];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic get_out(input int inst, output logic [4:0] rdy,
                         output logic vld, output int ch,
                         output logic [7:0] d, output logic ct);
    case (inst)
      0: begin
        rdy = {1'b0, rr_or}; vld = rr_ov; ch = int'(rr_oc);
        d = rr_od; ct = rr_ct;
      end
      1: begin
        rdy = {1'b0, fp_or}; vld = fp_ov; ch = int'(fp_oc);
        d = fp_od; ct = fp_ct;
      end
      default: begin
        rdy = c5_or; vld = c5_ov; ch = int'(c5_oc);
        d = c5_od; ct = c5_ct;
      end
    endcase
  endtask

  // Called at posedge+1: drive, check o_ready, queue expectation,
  // then pop and compare after the next edge.
  task automatic cycle(input int inst, input logic [4:0] vld,
                       input logic rdy, input logic [4:0] e_rdy,
                       input logic e_vld, input int e_ch,
                       input logic e_cont);
    exp_t e;
    logic [4:0] a_rdy;
    logic a_vld, a_ct;
    int a_ch;
    logic [7:0] a_d;
    rr_v = '0; fp_v = '0; c5_v = '0;
    rr_ir = 1'b1; fp_ir = 1'b1; c5_ir = 1'b1;
    case (inst)
      0: begin rr_v = vld[3:0]; rr_ir = rdy; end
      1: begin fp_v = vld[3:0]; fp_ir = rdy; end
      default: begin c5_v = vld; c5_ir = rdy; end
    endcase
    @(negedge clk);
    get_out(inst, a_rdy, a_vld, a_ch, a_d, a_ct);
    chk($sformatf("o_ready[i%0d]", inst), 32'(a_rdy), 32'(e_rdy));
    e.inst = inst;
    e.vld  = e_vld;
    e.ch   = e_ch;
    e.data = 8'hA0 + 8'(e_ch);
    e.cont = e_cont;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      get_out(e.inst, a_rdy, a_vld, a_ch, a_d, a_ct);
      chk($sformatf("o_valid[i%0d]", e.inst), 32'(a_vld), 32'(e.vld));
      chk($sformatf("o_channel[i%0d]", e.inst), 32'(a_ch), 32'(e.ch));
      chk($sformatf("o_data[i%0d]", e.inst), 32'(a_d), 32'(e.data));
      chk($sformatf("o_contention[i%0d]", e.inst), 32'(a_ct),
          32'(e.cont));
    end
  endtask

  initial begin
    // Round-robin scenario table, starting from reset (last = 3)
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1'b1};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1'b1};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2, 1'b0};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2, 1'b0};
    tbl[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2, 1'b0};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2, 1'b0};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2, 1'b0};
    tbl[10] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2, 1'b0};
    tbl[11] = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2, 1'b0};
    tbl[12] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2, 1'b0};
    tbl[13] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 3, 1'b1};
    tbl[14] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0, 1'b1};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 0, 1'b0};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
    tbl[17] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1, 1'b0};

    // Reset state with requests pending
    rr_v = 4'b1111; fp_v = 4'b1111; c5_v = 5'b11111;
    #7;
    chk("rst_o_valid", 32'(rr_ov), 32'd0);
    chk("rst_o_data", 32'(rr_od), 32'd0);
    chk("rst_o_channel", 32'(rr_oc), 32'd0);
    chk("rst_o_contention", 32'(rr_ct), 32'd0);
    chk("rst_o_ready_rr", 32'(rr_or), 32'd0);
    chk("rst_o_ready_fp", 32'(fp_or), 32'd0);
    chk("rst_o_ready_c5", 32'(c5_or), 32'd0);
    rr_v = '0; fp_v = '0; c5_v = '0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      cycle(0, {1'b0, tbl[i].vld}, tbl[i].rdy, {1'b0, tbl[i].e_rdy},
            tbl[i].e_vld, tbl[i].e_ch, tbl[i].e_cont);
    end

    // Async reset mid-cycle while holding channel 1 (last = 1)
    #2;
    rst = 1'b1;
    rr_v = 4'b1001;
    #1;
    chk("arst_o_valid", 32'(rr_ov), 32'd0);
    chk("arst_o_data", 32'(rr_od), 32'd0);
    chk("arst_o_channel", 32'(rr_oc), 32'd0);
    chk("arst_o_ready", 32'(rr_or), 32'd0);
    #1;
    rst = 1'b0;
    rr_v = '0;
    @(posedge clk);
    #1;
    cycle(0, 5'b01001, 1'b1, 5'b00001, 1'b1, 0, 1'b1);
    cycle(0, 5'b01001, 1'b1, 5'b01000, 1'b1, 3, 1'b1);

    // Fixed priority: channel 3 starved by channel 1
    for (int i = 0; i < 3; i++) begin
      cycle(1, 5'b01010, 1'b1, 5'b00010, 1'b1, 1, 1'b1);
    end
    cycle(1, 5'b01111, 1'b1, 5'b00001, 1'b1, 0, 1'b1);
    cycle(1, 5'b01000, 1'b1, 5'b01000, 1'b1, 3, 1'b0);

    // Five channels: wrap from last = 4 to 0, then 4
    cycle(2, 5'b10001, 1'b1, 5'b00001, 1'b1, 0, 1'b1);
    cycle(2, 5'b10001, 1'b1, 5'b10000, 1'b1, 4, 1'b1);
    cycle(2, 5'b10001, 1'b1, 5'b00001, 1'b1, 0, 1'b1);
    cycle(2, 5'b01000, 1'b1, 5'b01000, 1'b1, 3, 1'b0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
